alu_4bit: RTL and testbench

ALU_4BIT -- requirements
Module: alu_4bit

---
 rtl/alu_4bit.sv | 101 ++++++++++
 tb/tb_alu_4bit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_4bit.sv
// Single-cycle registered ALU: ADD/SUB/AND/OR/XOR/SLT with result flags.
// Define ALU_SHIFT_OPS_EN to enable logical shifts on opcodes 110/111.
module alu_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             In_Valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OpCode,
    output logic             Out_Valid,
    output logic [WIDTH-1:0] Result,
    output logic             SLT_Flag,
    output logic             Zero_Flag,
    output logic             Carry_Flag,
    output logic             Overflow_Flag
);

`ifdef ALU_SHIFT_OPS_EN
    localparam int unsigned ShW = $clog2(WIDTH);
`endif

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] op_result;
    logic             op_carry;
    logic             op_ovf;
    logic             op_slt;

    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] result_d, result_q;
    logic             slt_d, slt_q;
    logic             carry_d, carry_q;
    logic             ovf_d, ovf_q;

    always_comb begin
        sum_ext   = {1'b0, A} + {1'b0, B};
        // Top bit of the extended difference is the unsigned borrow (A < B).
        diff_ext  = {1'b0, A} - {1'b0, B};
        op_result = '0;
        op_carry  = 1'b0;
        op_ovf    = 1'b0;
        op_slt    = 1'b0;
        case (OpCode)
            3'b000: begin
                op_result = sum_ext[WIDTH-1:0];
                op_carry  = sum_ext[WIDTH];
                op_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
            end
            3'b001: begin
                op_result = diff_ext[WIDTH-1:0];
                op_carry  = diff_ext[WIDTH];
                op_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (diff_ext[WIDTH-1] != A[WIDTH-1]);
            end
            3'b010: op_result = A & B;
            3'b011: op_result = A | B;
            3'b100: op_result = A ^ B;
            3'b101: begin
                op_slt    = ($signed(A) < $signed(B));
                op_result = {{(WIDTH-1){1'b0}}, op_slt};
            end
`ifdef ALU_SHIFT_OPS_EN
            3'b110: op_result = A << B[ShW-1:0];
            3'b111: op_result = A >> B[ShW-1:0];
`endif
            default: ;
        endcase

        // Without a valid input the registered result and flags hold.
        out_valid_d = In_Valid;
        result_d    = In_Valid ? op_result : result_q;
        slt_d       = In_Valid ? op_slt    : slt_q;
        carry_d     = In_Valid ? op_carry  : carry_q;
        ovf_d       = In_Valid ? op_ovf    : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            slt_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            slt_q       <= slt_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
        end
    end

    assign Out_Valid     = out_valid_q;
    assign Result        = result_q;
    assign SLT_Flag      = slt_q;
    assign Zero_Flag     = (result_q == '0);
    assign Carry_Flag    = carry_q;
    assign Overflow_Flag = ovf_q;

endmodule

// File: tb/tb_alu_4bit.sv
// Directed self-checking bench for alu_4bit (WIDTH=4), immediate-assertion checks.
module tb_alu_4bit;

    logic       clk;
    logic       rst;
    logic       In_Valid;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] OpCode;
    logic       Out_Valid;
    logic [3:0] Result;
    logic       SLT_Flag;
    logic       Zero_Flag;
    logic       Carry_Flag;
    logic       Overflow_Flag;

    int checks;
    int failures;

    alu_4bit #(.WIDTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .In_Valid      (In_Valid),
        .A             (A),
        .B             (B),
        .OpCode        (OpCode),
        .Out_Valid     (Out_Valid),
        .Result        (Result),
        .SLT_Flag      (SLT_Flag),
        .Zero_Flag     (Zero_Flag),
        .Carry_Flag    (Carry_Flag),
        .Overflow_Flag (Overflow_Flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against expected values.
    task automatic expect_out(input string tag, input logic vld, input logic [3:0] res,
                              input logic z, input logic c, input logic v, input logic s);
        check({tag, ".valid"}, 32'(Out_Valid), 32'(vld));
        check({tag, ".result"}, 32'(Result), 32'(res));
        check({tag, ".zero"}, 32'(Zero_Flag), 32'(z));
        check({tag, ".carry"}, 32'(Carry_Flag), 32'(c));
        check({tag, ".ovf"}, 32'(Overflow_Flag), 32'(v));
        check({tag, ".slt"}, 32'(SLT_Flag), 32'(s));
    endtask

    // Present one operation for one edge; outputs are sampled 1 time unit later.
    task automatic do_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        In_Valid = 1'b1;
        OpCode   = op;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
        In_Valid = 1'b0;
    endtask

    task automatic do_idle();
        In_Valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst      = 1'b1;
        In_Valid = 1'b0;
        A        = '0;
        B        = '0;
        OpCode   = '0;

        @(posedge clk);
        @(posedge clk);
        #1;
        expect_out("reset", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Arithmetic, back to back
        do_op(3'b000, 4'd5, 4'd3);
        expect_out("add_5_3", 1'b1, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op(3'b000, 4'd15, 4'd1);
        expect_out("add_15_1", 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op(3'b000, 4'd7, 4'd1);
        expect_out("add_7_1", 1'b1, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op(3'b001, 4'd5, 4'd5);
        expect_out("sub_5_5", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op(3'b001, 4'd3, 4'd10);
        expect_out("sub_3_10", 1'b1, 4'b1001, 1'b0, 1'b1, 1'b1, 1'b0);
        do_op(3'b001, 4'd0, 4'd1);
        expect_out("sub_0_1", 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);

        // Idle cycle: valid drops, result and flags (including carry) hold
        do_idle();
        expect_out("hold_sub", 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);

        // Logic ops
        do_op(3'b010, 4'b1101, 4'b0111);
        expect_out("and", 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(3'b011, 4'b1101, 4'b0110);
        expect_out("or", 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(3'b100, 4'b1010, 4'b1010);
        expect_out("xor", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Signed less-than
        do_op(3'b101, 4'b1001, 4'b0010);
        expect_out("slt_neg_pos", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op(3'b101, 4'b1110, 4'b1010);
        expect_out("slt_false", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        // 1010 is -6 as a 4-bit signed value, so 5 < B is false.
        do_op(3'b101, 4'd5, 4'd10);
        expect_out("slt_5_10", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op(3'b101, 4'd5, 4'd6);
        expect_out("slt_5_6", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Opcodes 110/111
`ifdef ALU_SHIFT_OPS_EN
        do_op(3'b110, 4'b0011, 4'b0001);
        expect_out("op110", 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(3'b111, 4'b0011, 4'b0001);
        expect_out("op111", 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        do_op(3'b110, 4'b0011, 4'b0001);
        expect_out("op110", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op(3'b111, 4'b0011, 4'b0001);
        expect_out("op111", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        // One-cycle valid pulse, then hold
        do_op(3'b000, 4'd5, 4'd3);
        expect_out("pulse_add", 1'b1, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);
        do_idle();
        expect_out("pulse_hold", 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);
        do_idle();
        expect_out("pulse_hold2", 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset wins over a valid operation
        rst = 1'b1;
        do_op(3'b000, 4'd15, 4'd1);
        expect_out("rst_vs_valid", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // First operation after reset has normal latency
        do_op(3'b000, 4'd2, 4'd2);
        expect_out("post_rst_add", 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        do_idle();
        expect_out("post_rst_idle", 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
